// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and hazard match helper for the multiply issue controller
package mult_pkg;

  localparam int MULT_STAGES = 5;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } mult_entry_t;

  // A source hazards on an entry only when it is read, the entry is live and rd is not x0
  function automatic logic rs_match(input logic used, input logic [4:0] rs, input mult_entry_t e);
    return used && e.valid && (e.rd != 5'd0) && (rs == e.rd);
  endfunction

endpackage

// File: rtl/mult_shadow_pipe.sv
// rtl/mult_shadow_pipe.sv - 5-entry {valid, rd} shadow of the mult pipeline with inflight count
module mult_shadow_pipe
  import mult_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [4:0]                    in_rd,
  output mult_entry_t [MULT_STAGES-1:0] entries,
  output logic [2:0]                    inflight
);

  logic [2:0] next_count;

  // Count the valid bits the shadow will hold after this edge (new entry plus survivors)
  always_comb begin
    next_count = {2'b00, in_valid};
    for (int k = 0; k < MULT_STAGES - 1; k++) begin
      next_count = next_count + {2'b00, entries[k].valid};
    end
  end

  // Shift entries toward stage 5; reset or flush empties every stage
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entries  <= '0;
      inflight <= 3'd0;
    end else begin
      entries  <= {entries[MULT_STAGES-2:0], in_valid, in_rd};
      inflight <= next_count;
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - decode-side hazard/stall, mult start/kill and writeback select
module mult_issue_ctrl
  import mult_pkg::mult_entry_t;
  import mult_pkg::rs_match;
#(
  parameter int ALU_WB_LAT  = 2,
  parameter int MULT_STAGES = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kill_i,
  input  logic       dec_valid_i,
  input  logic       dec_is_mult_i,
  input  logic       dec_writes_rd_i,
  input  logic [4:0] dec_rd_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic       dec_rs1_used_i,
  input  logic       dec_rs2_used_i,
  output logic       issue_o,
  output logic       stall_o,
  output logic       mult_start_o,
  output logic       mult_kill_o,
  output logic       wb_sel_mult_o,
  output logic [4:0] wb_rd_o,
  output logic [2:0] inflight_o
);

  // A non-mult issued now writes back ALU_WB_LAT cycles later; the multiply that
  // reaches stage 5 at that moment currently sits in this entry (1-based).
  localparam int WB_IDX = MULT_STAGES - ALU_WB_LAT;

  mult_entry_t [MULT_STAGES-1:0] entries;
  logic                          raw;
  logic                          waw;
  logic                          wb_conf;
  logic                          alu_writer;
  logic                          go;

  mult_shadow_pipe u_shadow (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (kill_i),
    .in_valid (mult_start_o),
    .in_rd    (dec_rd_i & {5{dec_writes_rd_i}}),
    .entries  (entries),
    .inflight (inflight_o)
  );

  assign alu_writer = !dec_is_mult_i && dec_writes_rd_i;

  // Match decode sources/destination against every live shadow entry
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 0; k < MULT_STAGES; k++) begin
      raw = raw | rs_match(dec_rs1_used_i, dec_rs1_i, entries[k])
                | rs_match(dec_rs2_used_i, dec_rs2_i, entries[k]);
      waw = waw | (alu_writer && rs_match(1'b1, dec_rd_i, entries[k]));
    end
    wb_conf = alu_writer && entries[WB_IDX-1].valid && (entries[WB_IDX-1].rd != 5'd0);
  end

  // Issue/stall decisions and writeback select, all held inactive while in reset
  always_comb begin
    go            = !rst_i && dec_valid_i && !kill_i;
    stall_o       = go && (raw || waw || wb_conf);
    issue_o       = go && !stall_o;
    mult_start_o  = issue_o && dec_is_mult_i;
    mult_kill_o   = kill_i || rst_i;
    wb_sel_mult_o = !rst_i && entries[MULT_STAGES-1].valid && (entries[MULT_STAGES-1].rd != 5'd0);
    wb_rd_o       = wb_sel_mult_o ? entries[MULT_STAGES-1].rd : 5'd0;
  end

endmodule
